// File: rtl/fifo_frame_sched_pkg.sv
// Shared constants, state type and byte-map helper for the sniff-FIFO frame scheduler.
// The FE_FIFO_* values match the capture FIFO word encoding used by reg_main.
package fifo_frame_sched_pkg;

    localparam int FE_FIFO_CMD_BIT_LEN        = 2;
    localparam int FE_FIFO_DATA_LEN           = 16;
    localparam int FIFO_SCHED_BYTES_PER_FRAME = 4;

    localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] FE_FIFO_CMD_STRM   = 2'b11;
    localparam logic [FE_FIFO_DATA_LEN-1:0]    FE_FIFO_STRM_EMPTY = 16'h8E01;

    // Word served in place of a pop when the FIFO has nothing to give.
    localparam logic [17:0] FE_FIFO_STRM_MARKER = {FE_FIFO_CMD_STRM, FE_FIFO_STRM_EMPTY};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_t;

    function automatic logic [7:0] frame_byte(input logic [17:0] word,
                                              input logic [5:0]  status,
                                              input logic [1:0]  idx);
        case (idx)
            2'd0:    return 8'h00;
            2'd1:    return word[7:0];
            2'd2:    return word[15:8];
            default: return {status, word[17:16]};
        endcase
    endfunction

endpackage

// File: rtl/fifo_frame_sched_if.sv
// FIFO read port plus the two-requester byte handshake of the frame scheduler.
// master drives FIFO state and requests; slave is the scheduler itself.
interface fifo_frame_sched_if #(
    parameter int pDATA_WIDTH   = 18,
    parameter int pSTATUS_WIDTH = 6
);
    logic                     I_fifo_empty;
    logic [pDATA_WIDTH-1:0]   I_fifo_data;
    logic [pSTATUS_WIDTH-1:0] I_fifo_status;
    logic                     O_fifo_read;
    logic [1:0]               I_req;
    logic                     I_abort;
    logic [1:0]               O_gnt;
    logic [7:0]               O_data;
    logic [1:0]               O_byte_idx;

    modport master (
        output I_fifo_empty, I_fifo_data, I_fifo_status, I_req, I_abort,
        input  O_fifo_read, O_gnt, O_data, O_byte_idx
    );

    modport slave (
        input  I_fifo_empty, I_fifo_data, I_fifo_status, I_req, I_abort,
        output O_fifo_read, O_gnt, O_data, O_byte_idx
    );
endinterface

// File: rtl/fifo_frame_rr_arb.sv
// Two-way round-robin picker: one-hot winner from requests and the last frame owner.
module fifo_frame_rr_arb (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] winner
);
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_owner ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end
endmodule

// File: rtl/fifo_frame_sched.sv
// Shares the sniff-FIFO read port between the register and fast paths as locked 4-byte frames.
// Optional saturating frame counters are built when FIFO_SCHED_STATS_EN is defined.
module fifo_frame_sched
    import fifo_frame_sched_pkg::*;
#(
    parameter int pDATA_WIDTH   = 18,
    parameter int pSTATUS_WIDTH = 6,
    parameter int pSTAT_WIDTH   = 16
) (
    input  logic                   cwusb_clk,
    input  logic                   reset_n,
    input  logic                   I_enable,
    fifo_frame_sched_if.slave      bus,
    output logic                   O_busy,
    output logic                   O_owner,
    output logic [pSTAT_WIDTH-1:0] O_frames,
    output logic [pSTAT_WIDTH-1:0] O_empty_frames
);

    sched_state_t             state, state_d;
    logic [1:0]               byte_idx, byte_idx_d;
    logic                     owner, owner_d;
    logic [pDATA_WIDTH-1:0]   word_q, word_d;
    logic [pSTATUS_WIDTH-1:0] status_q, status_d;
    logic [1:0]               gnt_q, gnt_d;
    logic [1:0]               eligible;
    logic [1:0]               winner;
    logic                     start;

    // A requester that holds a grant this cycle has already been paid for its request.
    assign eligible = bus.I_req & ~gnt_q;

    fifo_frame_rr_arb u_arb (
        .req        (eligible),
        .last_owner (owner),
        .winner     (winner)
    );

    always_comb begin
        state_d    = state;
        byte_idx_d = byte_idx;
        owner_d    = owner;
        word_d     = word_q;
        status_d   = status_q;
        gnt_d      = 2'b00;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n && I_enable && (|eligible)) begin
                    start      = 1'b1;
                    state_d    = SERVE;
                    byte_idx_d = 2'd0;
                    gnt_d      = winner;
                    owner_d    = winner[1];
                    status_d   = bus.I_fifo_status;
                    word_d     = bus.I_fifo_empty ? pDATA_WIDTH'(FE_FIFO_STRM_MARKER) : bus.I_fifo_data;
                end
            end
            SERVE: begin
                if (bus.I_abort) begin
                    state_d = IDLE;
                end else if (bus.I_req[owner] && !gnt_q[owner]) begin
                    gnt_d      = owner ? 2'b10 : 2'b01;
                    byte_idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd2) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cwusb_clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            owner    <= 1'b1;
            word_q   <= '0;
            status_q <= '0;
            gnt_q    <= 2'b00;
        end else begin
            state    <= state_d;
            byte_idx <= byte_idx_d;
            owner    <= owner_d;
            word_q   <= word_d;
            status_q <= status_d;
            gnt_q    <= gnt_d;
        end
    end

    assign bus.O_fifo_read = start & ~bus.I_fifo_empty;
    assign bus.O_gnt       = gnt_q;
    assign bus.O_byte_idx  = byte_idx;
    assign bus.O_data      = (|gnt_q) ? frame_byte(word_q, status_q, byte_idx) : 8'h00;
    assign O_busy          = (state == SERVE);
    assign O_owner         = owner;

`ifdef FIFO_SCHED_STATS_EN
    logic [pSTAT_WIDTH-1:0] frames_q, empty_frames_q;

    always_ff @(posedge cwusb_clk) begin
        if (!reset_n) begin
            frames_q       <= '0;
            empty_frames_q <= '0;
        end else if (start) begin
            if (frames_q != '1) begin
                frames_q <= frames_q + 1'b1;
            end
            if (bus.I_fifo_empty && (empty_frames_q != '1)) begin
                empty_frames_q <= empty_frames_q + 1'b1;
            end
        end
    end

    assign O_frames       = frames_q;
    assign O_empty_frames = empty_frames_q;
`else
    assign O_frames       = '0;
    assign O_empty_frames = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_sched.sv
// Self-checking bench for fifo_frame_sched: table, directed frame sequences and randomized traffic
// checked every cycle against a frame-level reference model.
module tb_fifo_frame_sched;
    import fifo_frame_sched_pkg::*;

    logic        cwusb_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        O_busy;
    logic        O_owner;
    logic [15:0] O_frames;
    logic [15:0] O_empty_frames;

    fifo_frame_sched_if bus ();

    fifo_frame_sched dut (
        .cwusb_clk      (cwusb_clk),
        .reset_n        (reset_n),
        .I_enable       (enable),
        .bus            (bus),
        .O_busy         (O_busy),
        .O_owner        (O_owner),
        .O_frames       (O_frames),
        .O_empty_frames (O_empty_frames)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    int          vec_count   = 0;
    int          miscompares = 0;
    int          pop_count   = 0;
    logic        pop_pend    = 1'b0;
    logic [5:0]  status_v    = 6'h00;
    logic [17:0] fifo_q[$];
    logic [17:0] stage_q[$];
    logic [10:0] gnt_log[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: consume last cycle's pop, admit staged pushes, drive inputs, return at negedge.
    task automatic applyStimulus(input logic rstn, input logic en, input logic [1:0] req, input logic abort);
        @(posedge cwusb_clk);
        #1;
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
        reset_n           = rstn;
        enable            = en;
        bus.I_req         = req;
        bus.I_abort       = abort;
        bus.I_fifo_empty  = (fifo_q.size() == 0);
        bus.I_fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : 18'h0;
        bus.I_fifo_status = status_v;
        @(negedge cwusb_clk);
    endtask

    task automatic do_reset();
        fifo_q.delete();
        stage_q.delete();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
        gnt_log.delete();
        pop_count = 0;
    endtask

    task automatic run_cycles(input int n, input logic en, input logic [1:0] req);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, en, req, 1'b0);
    endtask

    task automatic check_log(input int i, input logic who, input logic [1:0] idx, input logic [7:0] data);
        if (gnt_log.size() > i) begin
            checkOutput($sformatf("log%0d", i), {21'h0, gnt_log[i]}, {21'h0, who, idx, data});
        end else begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL log%0d: got no grant, expected %0h", i, {who, idx, data});
        end
    endtask

    // Reference model: a frame is a 4-entry byte array handed out one byte per accepted request.
    logic       m_active = 1'b0;
    logic       m_owner  = 1'b1;
    logic [1:0] m_gnt    = 2'b00;
    int         m_sent   = 0;
    int         m_idx    = 0;
    int         m_frames = 0;
    int         m_empty  = 0;
    logic [7:0] m_bytes[4];

    always @(negedge cwusb_clk) begin
        logic [1:0]  elig;
        logic        win;
        logic        exp_read;
        logic [17:0] w;
        checkOutput("gnt", {30'h0, bus.O_gnt}, {30'h0, m_gnt});
        checkOutput("busy", {31'h0, O_busy}, {31'h0, m_active});
        checkOutput("owner", {31'h0, O_owner}, {31'h0, m_owner});
        if (m_gnt != 2'b00) begin
            checkOutput("data", {24'h0, bus.O_data}, {24'h0, m_bytes[m_idx]});
            checkOutput("byte_idx", {30'h0, bus.O_byte_idx}, m_idx);
        end
`ifdef FIFO_SCHED_STATS_EN
        checkOutput("frames", {16'h0, O_frames}, m_frames);
        checkOutput("empty_frames", {16'h0, O_empty_frames}, m_empty);
`else
        checkOutput("frames", {16'h0, O_frames}, 0);
        checkOutput("empty_frames", {16'h0, O_empty_frames}, 0);
`endif
        if (bus.O_gnt != 2'b00) gnt_log.push_back({bus.O_gnt[1], bus.O_byte_idx, bus.O_data});

        exp_read = 1'b0;
        if (!reset_n) begin
            m_active = 1'b0; m_owner = 1'b1; m_gnt = 2'b00;
            m_sent = 0; m_idx = 0; m_frames = 0; m_empty = 0;
        end else if (m_active) begin
            if (bus.I_abort) begin
                m_active = 1'b0;
                m_gnt    = 2'b00;
            end else if (bus.I_req[m_owner] && !m_gnt[m_owner]) begin
                m_idx  = m_sent;
                m_sent = m_sent + 1;
                m_gnt  = 2'b01 << m_owner;
                if (m_sent == FIFO_SCHED_BYTES_PER_FRAME) m_active = 1'b0;
            end else begin
                m_gnt = 2'b00;
            end
        end else begin
            elig = bus.I_req & ~m_gnt;
            if (enable && elig != 2'b00) begin
                win        = (elig == 2'b11) ? ~m_owner : elig[1];
                exp_read   = ~bus.I_fifo_empty;
                w          = bus.I_fifo_empty ? {FE_FIFO_CMD_STRM, FE_FIFO_STRM_EMPTY} : bus.I_fifo_data;
                m_bytes[0] = 8'h00;
                m_bytes[1] = 8'(w % 256);
                m_bytes[2] = 8'((w / 256) % 256);
                m_bytes[3] = 8'(bus.I_fifo_status * 4 + w / 65536);
                m_active   = 1'b1;
                m_sent     = 1;
                m_idx      = 0;
                m_owner    = win;
                m_gnt      = 2'b01 << win;
                if (m_frames < 65535) m_frames++;
                if (bus.I_fifo_empty && m_empty < 65535) m_empty++;
            end else begin
                m_gnt = 2'b00;
            end
        end
        checkOutput("fifo_read", {31'h0, bus.O_fifo_read}, {31'h0, exp_read});
        pop_pend = bus.O_fifo_read;
        if (bus.O_fifo_read) pop_count++;
    end

    typedef struct {
        logic       en;
        logic [1:0] req;
        logic       exp_read;
        logic [1:0] exp_gnt;
        logic [7:0] exp_data;
        logic [1:0] exp_idx;
        logic       exp_busy;
    } vec_t;

    vec_t        vecs[11];
    logic [17:0] mk;

    initial begin
        vecs[0]  = '{1'b1, 2'b01, 1'b1, 2'b00, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 2'b01, 8'h00, 2'd0, 1'b1};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00, 2'd0, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'b00, 8'h00, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 2'b01, 8'hC3, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 2'b00, 8'h00, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 2'b01, 8'hA5, 2'd2, 1'b1};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 2'b00, 8'h00, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 2'b01, 8'h56, 2'd3, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00, 2'd0, 1'b0};
        mk = {FE_FIFO_CMD_STRM, FE_FIFO_STRM_EMPTY};

        bus.I_req = 2'b00; bus.I_abort = 1'b0; bus.I_fifo_empty = 1'b1;
        bus.I_fifo_data = 18'h0; bus.I_fifo_status = 6'h0;

        // Single data frame from the table.
        status_v = 6'h15;
        do_reset();
        checkOutput("reset_owner", {31'h0, O_owner}, 32'd1);
        checkOutput("reset_gnt", {30'h0, bus.O_gnt}, 32'd0);
        stage_q.push_back(18'h2A5C3);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].en, vecs[i].req, 1'b0);
            checkOutput($sformatf("t1_read%0d", i), {31'h0, bus.O_fifo_read}, {31'h0, vecs[i].exp_read});
            checkOutput($sformatf("t1_gnt%0d", i), {30'h0, bus.O_gnt}, {30'h0, vecs[i].exp_gnt});
            checkOutput($sformatf("t1_busy%0d", i), {31'h0, O_busy}, {31'h0, vecs[i].exp_busy});
            if (vecs[i].exp_gnt != 2'b00) begin
                checkOutput($sformatf("t1_data%0d", i), {24'h0, bus.O_data}, {24'h0, vecs[i].exp_data});
                checkOutput($sformatf("t1_idx%0d", i), {30'h0, bus.O_byte_idx}, {30'h0, vecs[i].exp_idx});
            end
        end
        checkOutput("t1_pops", pop_count, 32'd1);

        // Empty FIFO yields a marker frame for the fast path.
        status_v = 6'h2A;
        do_reset();
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
`ifdef FIFO_SCHED_STATS_EN
        checkOutput("t2_empty_frames", {16'h0, O_empty_frames}, 32'd1);
`endif
        run_cycles(8, 1'b1, 2'b10);
        check_log(0, 1'b1, 2'd0, 8'h00);
        check_log(1, 1'b1, 2'd1, mk[7:0]);
        check_log(2, 1'b1, 2'd2, mk[15:8]);
        check_log(3, 1'b1, 2'd3, {6'h2A, mk[17:16]});
        checkOutput("t2_pops", pop_count, 32'd0);

        // Both requesters hold: frames alternate 0,1,0 and never interleave.
        status_v = 6'h00;
        do_reset();
        stage_q.push_back(18'h00A01); stage_q.push_back(18'h00B02); stage_q.push_back(18'h00C03);
        run_cycles(24, 1'b1, 2'b11);
        for (int i = 0; i < 12; i++) begin
            logic [17:0] wd;
            wd = 18'h00A01 + 18'((i / 4) * 18'h00101);
            check_log(i, (i / 4) == 1, 2'(i % 4), (i % 4 == 1) ? wd[7:0] : ((i % 4 == 2) ? wd[15:8] : 8'h00));
        end

        // Abort after byte 1 discards the word; the next frame serves the following word.
        do_reset();
        stage_q.push_back(18'h00011); stage_q.push_back(18'h00022);
        run_cycles(4, 1'b1, 2'b01);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
        checkOutput("t4_gnt", {30'h0, bus.O_gnt}, 32'd0);
        checkOutput("t4_busy", {31'h0, O_busy}, 32'd0);
        checkOutput("t4_read", {31'h0, bus.O_fifo_read}, 32'd1);
        run_cycles(4, 1'b1, 2'b01);
        checkOutput("t4_count", gnt_log.size(), 32'd4);
        check_log(1, 1'b0, 2'd1, 8'h11);
        check_log(2, 1'b0, 2'd0, 8'h00);
        check_log(3, 1'b0, 2'd1, 8'h22);

        // Reset while byte 2 is on the bus; the popped word is lost.
        do_reset();
        stage_q.push_back(18'h12345); stage_q.push_back(18'h06789);
        run_cycles(5, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
        checkOutput("t5_gnt", {30'h0, bus.O_gnt}, 32'd0);
        checkOutput("t5_busy", {31'h0, O_busy}, 32'd0);
        checkOutput("t5_owner", {31'h0, O_owner}, 32'd1);
        run_cycles(4, 1'b1, 2'b01);
        check_log(2, 1'b0, 2'd2, 8'h23);
        check_log(3, 1'b0, 2'd0, 8'h00);
        check_log(4, 1'b0, 2'd1, 8'h89);
        checkOutput("t5_pops", pop_count, 32'd2);

        // Dropping enable mid-frame still completes the frame, then holds off new ones.
        do_reset();
        stage_q.push_back(18'h0D0D1); stage_q.push_back(18'h0E0E2);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
        run_cycles(16, 1'b0, 2'b11);
        checkOutput("t6_count", gnt_log.size(), 32'd4);
        checkOutput("t6_busy", {31'h0, O_busy}, 32'd0);
        check_log(3, 1'b0, 2'd3, 8'h00);
        run_cycles(6, 1'b1, 2'b11);
        check_log(4, 1'b1, 2'd0, 8'h00);
        check_log(5, 1'b1, 2'd1, 8'hE2);

        // Randomized traffic, checked by the reference model every cycle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) stage_q.push_back(18'($urandom));
            status_v = 6'($urandom);
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                          2'($urandom), $urandom_range(0, 29) == 0);
        end
        run_cycles(2, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
